// File: rtl/mem1_req.sv
// mem1_req: first memory pipeline stage. Accepts a load/store from execute,
// issues at most one dcache request for it, then presents the op to Mem2.
// Misaligned and size-less ops skip the dcache and go straight to Mem2.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | nothing held; ready for a new op
// REQ   | dcache request outstanding for the held op
// HOLD  | held op presented to Mem2, waiting for m2_ready
// KILL  | op flushed while its request was outstanding; finish the
//       | dcache handshake and drop the op

module mem1_req #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_mem_op,
   input  logic [XLEN-1:0] ex_addr,
   input  logic [XLEN-1:0] ex_wdata,
   input  logic [4:0]      ex_rd,
   input  logic            flush,
   output logic            dc_req,
   input  logic            dc_gnt,
   output logic            dc_we,
   output logic [XLEN-3:0] dc_addr,
   output logic [3:0]      dc_be,
   output logic [XLEN-1:0] dc_wdata,
   output logic            m2_valid,
   input  logic            m2_ready,
   output logic [4:0]      m2_mem_op,
   output logic [1:0]      m2_addr_lo,
   output logic [4:0]      m2_rd,
   output logic            m2_misalign
);

   localparam int OP_STORE = 4;
   localparam int OP_WORD  = 3;
   localparam int OP_HALF  = 2;
   localparam int OP_BYTE  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [4:0]      op_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      be_q;
   logic [4:0]      rd_q;

   logic            accept;
   logic            no_size;
   logic            misalign_in;
   logic            skip_dc;
   logic [3:0]      be_in;
   logic [XLEN-1:0] wdata_in;

   // Handshake with execute; a flush in the same cycle blocks acceptance.
   always_comb begin
      ex_ready = 1'b0;
      if (!flush) begin
         case (state)
            IDLE:    ex_ready = 1'b1;
            HOLD:    ex_ready = m2_ready;
            default: ex_ready = 1'b0;
         endcase
      end
   end

   assign accept = ex_valid && ex_ready;

   // Classify the incoming op; word beats half beats byte if several size bits are set.
   always_comb begin
      no_size     = (ex_mem_op[OP_WORD:OP_BYTE] == 3'b000);
      misalign_in = 1'b0;
      be_in       = 4'b0000;
      wdata_in    = ex_wdata;
      if (ex_mem_op[OP_WORD]) begin
         misalign_in = (ex_addr[1:0] != 2'b00);
         be_in       = 4'b1111;
         wdata_in    = ex_wdata;
      end else if (ex_mem_op[OP_HALF]) begin
         misalign_in = ex_addr[0];
         be_in       = ex_addr[1] ? 4'b1100 : 4'b0011;
         wdata_in    = {2{ex_wdata[15:0]}};
      end else if (ex_mem_op[OP_BYTE]) begin
         be_in       = 4'b0001 << ex_addr[1:0];
         wdata_in    = {4{ex_wdata[7:0]}};
      end
      skip_dc = misalign_in || no_size;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = skip_dc ? HOLD : REQ;
         end
         REQ: begin
            if (dc_gnt)
               state_nxt = flush ? IDLE : HOLD;
            else if (flush)
               state_nxt = KILL;
         end
         HOLD: begin
            if (flush)
               state_nxt = IDLE;
            else if (m2_ready) begin
               if (accept)
                  state_nxt = skip_dc ? HOLD : REQ;
               else
                  state_nxt = IDLE;
            end
         end
         KILL: begin
            if (dc_gnt)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dc_req      <= 1'b0;
         m2_valid    <= 1'b0;
         m2_misalign <= 1'b0;
      end else begin
         state       <= state_nxt;
         dc_req      <= (state_nxt == REQ) || (state_nxt == KILL);
         m2_valid    <= (state_nxt == HOLD);
         m2_misalign <= (state_nxt == HOLD) && (accept ? misalign_in : m2_misalign);
      end
   end

   // Op payload, captured on acceptance and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= '0;
      end else if (accept) begin
         op_q    <= ex_mem_op;
         addr_q  <= ex_addr;
         wdata_q <= wdata_in;
         be_q    <= be_in;
         rd_q    <= ex_rd;
      end
   end

   assign dc_we      = op_q[OP_STORE];
   assign dc_addr    = addr_q[XLEN-1:2];
   assign dc_be      = be_q;
   assign dc_wdata   = wdata_q;
   assign m2_mem_op  = op_q;
   assign m2_addr_lo = addr_q[1:0];
   assign m2_rd      = rd_q;

endmodule

// File: tb/tb_mem1_req.sv
// Directed bench for mem1_req. Expected dcache and Mem2 transactions are
// queued when an op is issued; a negedge monitor pops and compares them on
// each dc_req/dc_gnt and m2_valid/m2_ready handshake.

module tb_mem1_req;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_mem_op;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [4:0]  ex_rd;
   logic        flush;
   logic        dc_req;
   logic        dc_gnt;
   logic        dc_we;
   logic [29:0] dc_addr;
   logic [3:0]  dc_be;
   logic [31:0] dc_wdata;
   logic        m2_valid;
   logic        m2_ready;
   logic [4:0]  m2_mem_op;
   logic [1:0]  m2_addr_lo;
   logic [4:0]  m2_rd;
   logic        m2_misalign;

   mem1_req #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush),
      .dc_req(dc_req), .dc_gnt(dc_gnt), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_be(dc_be), .dc_wdata(dc_wdata),
      .m2_valid(m2_valid), .m2_ready(m2_ready), .m2_mem_op(m2_mem_op),
      .m2_addr_lo(m2_addr_lo), .m2_rd(m2_rd), .m2_misalign(m2_misalign)
   );

   // op encodings: store|word|half|byte|signed
   localparam logic [4:0] OP_SB  = 5'b10010;
   localparam logic [4:0] OP_SH  = 5'b10100;
   localparam logic [4:0] OP_SW  = 5'b11000;
   localparam logic [4:0] OP_LB  = 5'b00011;
   localparam logic [4:0] OP_LBU = 5'b00010;
   localparam logic [4:0] OP_LH  = 5'b00101;
   localparam logic [4:0] OP_LHU = 5'b00100;
   localparam logic [4:0] OP_LW  = 5'b01001;
   localparam logic [4:0] OP_NOS = 5'b10000;

   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dc_exp_t;

   typedef struct packed {
      logic [4:0] op;
      logic [1:0] lo;
      logic [4:0] rd;
      logic       mis;
   } m2_exp_t;

   dc_exp_t dc_q[$];
   m2_exp_t m2_q[$];

   int vectors = 0;
   int errors  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op, queue its expected transactions, return 1ns after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input bit exp_dc, input logic [3:0] be,
                        input logic [31:0] dwd, input bit exp_m2, input bit mis);
      bit got;
      dc_exp_t d;
      m2_exp_t m;
      got = 1'b0;
      if (exp_dc) begin
         d.we = op[4]; d.addr = addr[31:2]; d.be = be; d.wdata = dwd;
         dc_q.push_back(d);
      end
      if (exp_m2) begin
         m.op = op; m.lo = addr[1:0]; m.rd = rd; m.mis = mis;
         m2_q.push_back(m);
      end
      ex_mem_op = op; ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ex_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         vectors++;
         errors++;
         $display("FAIL issue_timeout: ex_ready never seen for addr 0x%0h", addr);
      end
      step();
      ex_valid = 1'b0;
   endtask

   // Monitor: compare every handshake against the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dc_req && dc_gnt) begin
            if (dc_q.size() == 0) begin
               chk("dc_unexpected", 32'(dc_addr), 32'hFFFF_FFFF);
            end else begin
               dc_exp_t e;
               e = dc_q.pop_front();
               chk("dc_we", 32'(dc_we), 32'(e.we));
               chk("dc_addr", 32'(dc_addr), 32'(e.addr));
               chk("dc_be", 32'(dc_be), 32'(e.be));
               if (e.we) chk("dc_wdata", dc_wdata, e.wdata);
            end
         end
         if (m2_valid && m2_ready) begin
            if (m2_q.size() == 0) begin
               chk("m2_unexpected", 32'(m2_rd), 32'hFFFF_FFFF);
            end else begin
               m2_exp_t e;
               e = m2_q.pop_front();
               chk("m2_mem_op", 32'(m2_mem_op), 32'(e.op));
               chk("m2_addr_lo", 32'(m2_addr_lo), 32'(e.lo));
               chk("m2_rd", 32'(m2_rd), 32'(e.rd));
               chk("m2_misalign", 32'(m2_misalign), 32'(e.mis));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_mem_op = '0; ex_addr = '0; ex_wdata = '0;
      ex_rd = '0; flush = 1'b0; dc_gnt = 1'b1; m2_ready = 1'b1;
      step(); step();
      chk("rst_dc_req", 32'(dc_req), 32'd0);
      chk("rst_m2_valid", 32'(m2_valid), 32'd0);
      chk("rst_dc_be", 32'(dc_be), 32'd0);
      chk("rst_dc_we", 32'(dc_we), 32'd0);
      chk("rst_m2_misalign", 32'(m2_misalign), 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      rst_n = 1'b1;

      // sb with immediate grant: one request cycle, Mem2 one cycle later
      issue(OP_SB, 32'h0000_1003, 32'h0000_00AB, 5'd1, 1, 4'b1000, 32'hABAB_ABAB, 1, 0);
      @(negedge clk);
      chk("sb_req_cycle", 32'(dc_req), 32'd1);
      chk("sb_no_m2_yet", 32'(m2_valid), 32'd0);
      @(negedge clk);
      chk("sb_req_dropped", 32'(dc_req), 32'd0);
      chk("sb_m2_valid", 32'(m2_valid), 32'd1);
      step(); step();

      // misaligned lh skips the dcache, lw follows back to back
      issue(OP_LH, 32'h0000_2001, 32'h0, 5'd2, 0, 4'b0000, 32'h0, 1, 1);
      issue(OP_LW, 32'h0000_2004, 32'h0, 5'd3, 1, 4'b1111, 32'h0, 1, 0);
      @(negedge clk);
      chk("lw_b2b_req", 32'(dc_req), 32'd1);
      chk("lw_b2b_be", 32'(dc_be), 32'hF);
      step(); step(); step();

      // lhu with grant withheld for three cycles
      dc_gnt = 1'b0;
      issue(OP_LHU, 32'h0000_3002, 32'h0, 5'd4, 1, 4'b1100, 32'h0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dc_gnt = 1'b1;
         @(negedge clk);
         chk("lhu_wait_req", 32'(dc_req), 32'd1);
         chk("lhu_wait_addr", 32'(dc_addr), 32'h0000_0C00);
         chk("lhu_wait_be", 32'(dc_be), 32'hC);
         chk("lhu_wait_ready", 32'(ex_ready), 32'd0);
         chk("lhu_wait_m2", 32'(m2_valid), 32'd0);
         step();
      end
      @(negedge clk);
      chk("lhu_m2_after_gnt", 32'(m2_valid), 32'd1);
      step(); step();

      // lw flushed in its second REQ cycle, granted two cycles later from KILL
      dc_gnt = 1'b0;
      issue(OP_LW, 32'h0000_0040, 32'h0, 5'd5, 1, 4'b1111, 32'h0, 0, 0);
      @(negedge clk);
      chk("kill_req_c1", 32'(dc_req), 32'd1);
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("kill_req_c2", 32'(dc_req), 32'd1);
      step();
      @(negedge clk);
      chk("kill_req_c3", 32'(dc_req), 32'd1);
      chk("kill_be_c3", 32'(dc_be), 32'hF);
      chk("kill_m2_c3", 32'(m2_valid), 32'd0);
      step();
      flush = 1'b0;
      dc_gnt = 1'b1;
      @(negedge clk);
      chk("kill_req_c4", 32'(dc_req), 32'd1);
      chk("kill_m2_c4", 32'(m2_valid), 32'd0);
      step();
      @(negedge clk);
      chk("kill_idle_req", 32'(dc_req), 32'd0);
      chk("kill_idle_m2", 32'(m2_valid), 32'd0);
      chk("kill_idle_ready", 32'(ex_ready), 32'd1);
      step();

      // flush in REQ with grant the same cycle goes straight to IDLE
      issue(OP_SW, 32'h0000_0008, 32'h1234_5678, 5'd6, 1, 4'b1111, 32'h1234_5678, 0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flushgnt_m2", 32'(m2_valid), 32'd0);
      chk("flushgnt_req", 32'(dc_req), 32'd0);
      step();

      // flush in HOLD blocks a presented op and empties the stage
      m2_ready = 1'b0;
      issue(OP_LW, 32'h0000_0002, 32'h0, 5'd7, 0, 4'b0000, 32'h0, 0, 1);
      flush = 1'b1;
      ex_valid = 1'b1; ex_mem_op = OP_LB; ex_addr = 32'h0000_0100;
      @(negedge clk);
      chk("flushhold_ready", 32'(ex_ready), 32'd0);
      chk("flushhold_mis", 32'(m2_misalign), 32'd1);
      step();
      flush = 1'b0; ex_valid = 1'b0; m2_ready = 1'b1;
      @(negedge clk);
      chk("flushhold_m2", 32'(m2_valid), 32'd0);
      chk("flushhold_req", 32'(dc_req), 32'd0);
      step();

      // Mem2 stalls for five cycles, then accepts while a new op is taken
      m2_ready = 1'b0;
      issue(OP_LBU, 32'h0000_0005, 32'h0, 5'd9, 1, 4'b0010, 32'h0, 1, 0);
      step();
      ex_valid = 1'b1; ex_mem_op = OP_SW; ex_addr = 32'h0000_0020;
      ex_wdata = 32'hCAFE_F00D; ex_rd = 5'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_m2_valid", 32'(m2_valid), 32'd1);
         chk("stall_ready", 32'(ex_ready), 32'd0);
         chk("stall_m2_rd", 32'(m2_rd), 32'd9);
         chk("stall_m2_lo", 32'(m2_addr_lo), 32'd1);
         chk("stall_m2_op", 32'(m2_mem_op), 32'(OP_LBU));
         step();
      end
      m2_ready = 1'b1;
      issue(OP_SW, 32'h0000_0020, 32'hCAFE_F00D, 5'd0, 1, 4'b1111, 32'hCAFE_F00D, 1, 0);
      @(negedge clk);
      chk("stall_release_req", 32'(dc_req), 32'd1);
      chk("stall_release_addr", 32'(dc_addr), 32'h0000_0008);
      step(); step();

      // assorted lanes and no-request ops, streamed
      issue(OP_SH,  32'h0000_0006, 32'h0000_BEEF, 5'd10, 1, 4'b1100, 32'hBEEF_BEEF, 1, 0);
      issue(OP_SB,  32'h0000_0001, 32'h0000_005A, 5'd11, 1, 4'b0010, 32'h5A5A_5A5A, 1, 0);
      issue(OP_LB,  32'h0000_0000, 32'h0,         5'd12, 1, 4'b0001, 32'h0,         1, 0);
      issue(OP_NOS, 32'h0000_0010, 32'h0,         5'd13, 0, 4'b0000, 32'h0,         1, 0);
      issue(OP_LH,  32'h0000_0003, 32'h0,         5'd14, 0, 4'b0000, 32'h0,         1, 1);
      issue(OP_SW,  32'h0000_000C, 32'h0BAD_CAFE, 5'd15, 1, 4'b1111, 32'h0BAD_CAFE, 1, 0);
      issue(OP_SH,  32'h0000_0000, 32'h0000_7788, 5'd16, 1, 4'b0011, 32'h7788_7788, 1, 0);
      step(); step(); step();

      // asynchronous reset in the middle of an outstanding request
      dc_gnt = 1'b0;
      issue(OP_LW, 32'h0000_0040, 32'h0, 5'd17, 1, 4'b1111, 32'h0, 1, 0);
      @(negedge clk);
      chk("arst_req_before", 32'(dc_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dc_req", 32'(dc_req), 32'd0);
      chk("arst_m2_valid", 32'(m2_valid), 32'd0);
      chk("arst_dc_be", 32'(dc_be), 32'd0);
      chk("arst_dc_we", 32'(dc_we), 32'd0);
      dc_q.delete();
      m2_q.delete();
      dc_gnt = 1'b1;
      begin
         dc_exp_t d;
         m2_exp_t m;
         d.we = 1'b1; d.addr = 30'h0; d.be = 4'b1100; d.wdata = 32'h1234_1234;
         dc_q.push_back(d);
         m.op = OP_SH; m.lo = 2'd2; m.rd = 5'd18; m.mis = 1'b0;
         m2_q.push_back(m);
      end
      ex_mem_op = OP_SH; ex_addr = 32'h0000_0002; ex_wdata = 32'h0000_1234;
      ex_rd = 5'd18; ex_valid = 1'b1;
      #1;
      rst_n = 1'b1;
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("arst_first_req", 32'(dc_req), 32'd1);
      chk("arst_first_be", 32'(dc_be), 32'hC);
      step(); step(); step();

      chk("dc_queue_empty", 32'(dc_q.size()), 32'd0);
      chk("m2_queue_empty", 32'(m2_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem1_req.md
MEM1_REQ -- requirements
Module: mem1_req

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only XLEN=32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage presents a memory op.
REQ-005 ex_ready  output  1  block accepts the op this cycle; transfer occurs when ex_valid & ex_ready.
REQ-006 ex_mem_op  input  5  bit4 = store, bit3 = word, bit2 = half, bit1 = byte, bit0 = signed load.
REQ-007 ex_addr  input  XLEN  effective byte address.
REQ-008 ex_wdata  input  XLEN  store source data.
REQ-009 ex_rd  input  5  destination register index.
REQ-010 flush  input  1  kill any in-flight op.
REQ-011 dc_req  output  1  dcache request.
REQ-012 dc_gnt  input  1  dcache accepts the request this cycle.
REQ-013 dc_we  output  1  store request.
REQ-014 dc_addr  output  XLEN-2  word address, ex_addr[31:2].
REQ-015 dc_be  output  4  byte enables.
REQ-016 dc_wdata  output  XLEN  lane-replicated store data.
REQ-017 m2_valid  output  1  op is presented to the Mem2 stage.
REQ-018 m2_ready  input  1  Mem2 accepts the op.
REQ-019 m2_mem_op  output  5  registered ex_mem_op.
REQ-020 m2_addr_lo  output  2  registered ex_addr[1:0], used for load lane select.
REQ-021 m2_rd  output  5  registered ex_rd.
REQ-022 m2_misalign  output  1  op was misaligned and was not sent to the dcache.

Function
REQ-023 The block SHALL implement the states IDLE, REQ, HOLD and KILL.
REQ-024 ex_ready SHALL be 1 in IDLE, equal to m2_ready in HOLD, and 0 in REQ and KILL.
REQ-025 On acceptance, the block SHALL register op, addr, wdata and rd, and SHALL keep them stable until the next acceptance.
REQ-026 Misalignment SHALL be defined as: half with addr[0]=1, or word with addr[1:0]!=0; byte ops are never misaligned.
REQ-027 An accepted op that is misaligned, or has ex_mem_op[3:1]==0, SHALL go directly to HOLD with no dcache request; m2_misalign=1 only for the misaligned case.
REQ-028 Any other accepted op SHALL go to REQ.
REQ-029 In REQ, dc_req=1 and dc_we=op[4]; on dc_gnt the block SHALL move to HOLD in the next cycle.
REQ-030 dc_be SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111.
REQ-031 dc_be SHALL apply to both loads and stores.
REQ-032 dc_wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-033 In HOLD, m2_valid=1; on m2_ready the block SHALL go to IDLE, or if ex_valid is high, accept the new op and go to REQ or HOLD per REQ-027/REQ-028 (back-to-back, one op per cycle for no-request ops).
REQ-034 dc_req, once asserted, SHALL NOT drop, and its fields SHALL NOT change until dc_gnt.
REQ-035 Minimum latency SHALL be: acceptance -> REQ (1 cycle) -> gnt -> m2_valid the next cycle, i.e. 2 cycles with immediate gnt.
REQ-036 flush in IDLE or HOLD SHALL force IDLE next cycle with m2_valid=0, and ex_valid that cycle SHALL be ignored (ex_ready forced 0).
REQ-037 flush in REQ with dc_gnt the same cycle SHALL go to IDLE.
REQ-038 flush in REQ without dc_gnt SHALL go to KILL.
REQ-039 KILL SHALL hold dc_req with unchanged fields until dc_gnt, then go to IDLE without asserting m2_valid.
REQ-040 flush in KILL SHALL have no additional effect.
REQ-041 dc_gnt outside REQ/KILL SHALL be ignored.

Reset
REQ-042 rst_n low SHALL immediately (asynchronously) force state=IDLE, dc_req=0, m2_valid=0 and m2_misalign=0.
REQ-043 rst_n low SHALL immediately clear all registered payload to 0, so dc_be=0 and dc_we=0.
REQ-044 Reset mid-REQ SHALL abandon the request; the dcache is reset by the same rst_n.
REQ-045 The first acceptance SHALL be possible in the first clock after rst_n deasserts.

Verification
REQ-046 sb, addr=0x1003, wdata=0x000000AB, gnt immediate, m2_ready=1 -> dc_req one cycle, dc_we=1, dc_addr=0x400, dc_be=4'b1000, dc_wdata=0xABABABAB; m2_valid next cycle with m2_addr_lo=3.
REQ-047 lh at addr=0x2001 -> no dc_req; m2_valid=1 next cycle with m2_misalign=1; lw at 0x2004 right after -> accepted while m2_ready=1, dc_be=4'b1111.
REQ-048 lhu at 0x3002, dc_gnt held low 3 cycles -> dc_req and fields stable for 4 cycles, ex_ready=0 throughout, m2_valid one cycle after gnt.
REQ-049 lw issued, flush in the second REQ cycle, gnt 2 cycles later -> dc_req held through KILL, m2_valid never asserted, IDLE after gnt.
REQ-050 HOLD with m2_ready=0 for 5 cycles -> m2_* stable, ex_ready=0; then m2_ready=1 with ex_valid=1 -> new op accepted that same cycle.
REQ-051 rst_n pulsed low mid-REQ (asynchronously, between edges) -> dc_req and m2_valid drop immediately; op accepted the first cycle after release.
